// File: rtl/pwm_controller_if.sv
// Register bus between the PWM block and its host.
// Latency: writes take effect on the posedge where WE is sampled; RD is combinational.
// Backpressure: none. The slave accepts one write per cycle and is always ready.
//
// Signals: WD write data, WE write enable, A register select, RD read data.
interface pwm_controller_if;
    logic [31:0] WD;
    logic        WE;
    logic [1:0]  A;
    logic [31:0] RD;

    modport master (output WD, output WE, output A, input RD);
    modport slave  (input WD, input WE, input A, output RD);
endinterface

// File: rtl/pwm_controller.sv
// 16-bit PWM generator with double-buffered PERIOD/DUTY and a period-end interrupt.
// Latency: register writes land on the write edge; PWM follows registered state in the next cycle.
// Backpressure: none. The bus is always ready, and period_irq is a pulse with no acknowledge.
//
// Ports: clk, rst_n (async, active-low); bus (slave: WD/WE/A/RD);
//        PWM waveform out; period_irq one-cycle pulse after each period end.
//        A selects 0 CTRL {POL,EN}, 1 PERIOD, 2 DUTY, 3 STATUS {pending,cnt} (read-only).
module pwm_controller (
    input  logic               clk,
    input  logic               rst_n,
    pwm_controller_if.slave    bus,
    output logic               PWM,
    output logic               period_irq
);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PERIOD = 2'd1;
    localparam logic [1:0] A_DUTY   = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic        en;
    logic        pol;
    logic [15:0] per_stg;
    logic [15:0] duty_stg;
    logic [15:0] per_act;
    logic [15:0] duty_act;
    logic [15:0] cnt;
    logic        pending;

    logic wr_ctrl;
    logic wr_per;
    logic wr_duty;
    logic wr_stg;
    logic en_nxt;
    logic en_rise;
    logic period_end;

    assign wr_ctrl = bus.WE && (bus.A == A_CTRL);
    assign wr_per  = bus.WE && (bus.A == A_PERIOD);
    assign wr_duty = bus.WE && (bus.A == A_DUTY);
    assign wr_stg  = wr_per || wr_duty;

    // EN after this edge; a CTRL write rewriting EN=1 while enabled is not a rise.
    assign en_nxt     = wr_ctrl ? bus.WD[0] : en;
    assign en_rise    = wr_ctrl && bus.WD[0] && !en;
    assign period_end = en && (cnt == per_act);

    // Control and staging registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= 1'b0;
            pol      <= 1'b0;
            per_stg  <= 16'd0;
            duty_stg <= 16'd0;
        end else begin
            if (wr_ctrl) begin
                en  <= bus.WD[0];
                pol <= bus.WD[1];
            end
            if (wr_per) begin
                per_stg <= bus.WD[15:0];
            end
            if (wr_duty) begin
                duty_stg <= bus.WD[15:0];
            end
        end
    end

    // Counter, active copies and pending flag. The active copies always load
    // from the staging registers as they stood before this edge, so a staging
    // write coinciding with a period end is deferred to the following period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 16'd0;
            per_act    <= 16'd0;
            duty_act   <= 16'd0;
            pending    <= 1'b0;
            period_irq <= 1'b0;
        end else begin
            // A disabling write on a period-end edge suppresses the pulse.
            period_irq <= period_end && en_nxt;
            if (!en_nxt) begin
                cnt     <= 16'd0;
                pending <= 1'b0;
            end else if (en_rise) begin
                cnt      <= 16'd0;
                per_act  <= per_stg;
                duty_act <= duty_stg;
                pending  <= 1'b0;
            end else if (period_end) begin
                cnt <= 16'd0;
                if (pending) begin
                    per_act  <= per_stg;
                    duty_act <= duty_stg;
                end
                pending <= wr_stg;
            end else begin
                cnt     <= cnt + 16'd1;
                pending <= pending || wr_stg;
            end
        end
    end

    // duty_act > per_act keeps cnt < duty_act true all period (constant active);
    // duty_act == 0 never satisfies it (constant inactive).
    assign PWM = pol ^ (en && (cnt < duty_act));

    always_comb begin
        bus.RD = 32'd0;
        case (bus.A)
            A_CTRL:   bus.RD = {30'd0, pol, en};
            A_PERIOD: bus.RD = {16'd0, per_stg};
            A_DUTY:   bus.RD = {16'd0, duty_stg};
            A_STATUS: bus.RD = {15'd0, pending, cnt};
            default:  bus.RD = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_pwm_controller.sv
// Scoreboard bench for pwm_controller: stimulus queues expectations tagged with a cycle,
// a negedge monitor pops and compares PWM, period_irq and RD in that cycle.
// Expected values are hand-derived per directed scenario.
module tb_pwm_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm;
    logic irq;
    int unsigned cyc_cnt = 0;
    int n_checks = 0;
    int n_err = 0;

    localparam int K_PWM = 0;
    localparam int K_IRQ = 1;
    localparam int K_RD  = 2;

    typedef struct {
        int unsigned cyc;
        int          kind;
        logic [31:0] exp;
    } sb_t;

    sb_t   sb_q[$];
    string nm_q[$];

    pwm_controller_if bus ();

    pwm_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .PWM        (pwm),
        .period_irq (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: compare every expectation due at or before the current cycle.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc <= cyc_cnt) begin
                logic [31:0] act;
                case (sb_q[i].kind)
                    K_PWM:   act = {31'd0, pwm};
                    K_IRQ:   act = {31'd0, irq};
                    default: act = bus.RD;
                endcase
                n_checks++;
                if (sb_q[i].cyc != cyc_cnt || act !== sb_q[i].exp) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                             nm_q[i], act, sb_q[i].exp, cyc_cnt, sb_q[i].cyc);
                end
                sb_q.delete(i);
                nm_q.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input string nm, input logic [31:0] e);
        sb_t it;
        it.cyc  = cyc_cnt;
        it.kind = kind;
        it.exp  = e;
        sb_q.push_back(it);
        nm_q.push_back(nm);
    endtask

    // Outputs only (used in cycles where A is not on STATUS).
    task automatic chk_out(input string tag, input bit p, input bit q);
        push(K_PWM, {tag, ".pwm"}, {31'd0, p});
        push(K_IRQ, {tag, ".irq"}, {31'd0, q});
    endtask

    task automatic chk(input string tag, input int c, input bit pend, input bit p, input bit q);
        push(K_RD, {tag, ".status"}, {15'd0, pend, c[15:0]});
        chk_out(tag, p, q);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.A  = a;
        bus.WD = d;
        bus.WE = 1'b1;
        tick();
        bus.WE = 1'b0;
        bus.A  = 2'd3;
        bus.WD = 32'd0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] e);
        bus.A = a;
        push(K_RD, tag, e);
        tick();
        bus.A = 2'd3;
    endtask

    // n cycles of steady running starting at counter value c0. irq is high in
    // the cycle where cnt==0, except the first cycle after an enable (fresh).
    task automatic run(input string tag, input int c0, input int n, input int per,
                       input int duty, input bit pend, input bit pol, input bit fresh);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (c0 + k) % (per + 1);
            chk(tag, c, pend, pol ^ (c < duty), (c == 0) && !(fresh && k == 0));
            tick();
        end
    endtask

    initial begin
        bus.A  = 2'd3;
        bus.WD = 32'd0;
        bus.WE = 1'b0;
        tick();
        // Reset state: all registers zero, outputs low.
        rd_chk("rst.ctrl", 2'd0, 32'd0);
        rd_chk("rst.period", 2'd1, 32'd0);
        rd_chk("rst.duty", 2'd2, 32'd0);
        chk("rst", 0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        chk("idle", 0, 1'b0, 1'b0, 1'b0);
        tick();

        // 9/3 waveform: 3 high, 7 low, irq every 10 cycles.
        wr(2'd1, 32'd9);
        wr(2'd2, 32'd3);
        rd_chk("rd.period", 2'd1, 32'd9);
        wr(2'd0, 32'd1);
        rd_chk("rd.ctrl", 2'd0, 32'd1);
        // The read above consumed counter value 0 (irq 0, pwm 1).
        run("p93", 1, 29, 9, 3, 1'b0, 1'b0, 1'b0);

        // DUTY=7 written at cnt=4: deferred to next period.
        run("d7a", 0, 4, 9, 3, 1'b0, 1'b0, 1'b0);
        chk_out("d7w", 1'b0, 1'b0);
        wr(2'd2, 32'd7);
        run("d7p", 5, 5, 9, 3, 1'b1, 1'b0, 1'b0);
        run("d7n", 0, 10, 9, 7, 1'b0, 1'b0, 1'b0);

        // DUTY=5 on the period-end edge: next period keeps 7, pending stays.
        run("d5a", 0, 9, 9, 7, 1'b0, 1'b0, 1'b0);
        chk_out("d5w", 1'b0, 1'b0);
        wr(2'd2, 32'd5);
        run("d5o", 0, 10, 9, 7, 1'b1, 1'b0, 1'b0);
        run("d5n", 0, 10, 9, 5, 1'b0, 1'b0, 1'b0);

        // DUTY=0 constant low, DUTY=20 constant high, then POL=1 inverts.
        chk_out("d0w", 1'b1, 1'b1);
        wr(2'd2, 32'd0);
        run("d0p", 1, 9, 9, 5, 1'b1, 1'b0, 1'b0);
        run("d0", 0, 10, 9, 0, 1'b0, 1'b0, 1'b0);
        chk_out("d20w", 1'b0, 1'b1);
        wr(2'd2, 32'd20);
        run("d20p", 1, 9, 9, 0, 1'b1, 1'b0, 1'b0);
        run("d20", 0, 10, 9, 20, 1'b0, 1'b0, 1'b0);
        chk_out("polw", 1'b1, 1'b1);
        wr(2'd0, 32'd3);
        run("pol", 1, 4, 9, 20, 1'b0, 1'b1, 1'b0);
        chk_out("pol0w", 1'b0, 1'b0);
        wr(2'd0, 32'd1);

        // Disable at cnt=6, staging writes while off, re-enable.
        chk_out("offw", 1'b1, 1'b0);
        wr(2'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("off", 0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        wr(2'd1, 32'd3);
        chk("offstg", 0, 1'b0, 1'b0, 1'b0);
        tick();
        rd_chk("off.period", 2'd1, 32'd3);
        wr(2'd0, 32'd1);
        run("reen", 0, 8, 3, 20, 1'b0, 1'b0, 1'b1);

        // PERIOD=0: one-cycle period, irq stuck high.
        chk_out("per0w", 1'b1, 1'b1);
        wr(2'd1, 32'd0);
        run("per0p", 1, 3, 3, 20, 1'b1, 1'b0, 1'b0);
        run("per0", 0, 5, 0, 20, 1'b0, 1'b0, 1'b0);

        // Short reset pulse mid-run clears everything.
        wr(2'd2, 32'd2);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        chk("rstp", 0, 1'b0, 1'b0, 1'b0);
        tick();
        rd_chk("rstp.ctrl", 2'd0, 32'd0);
        rd_chk("rstp.period", 2'd1, 32'd0);
        rd_chk("rstp.duty", 2'd2, 32'd0);
        for (int k = 0; k < 2; k++) begin
            chk("rstidle", 0, 1'b0, 1'b0, 1'b0);
            tick();
        end

        // Resume 4/2, then a write to STATUS is ignored.
        wr(2'd1, 32'd4);
        wr(2'd2, 32'd2);
        wr(2'd0, 32'd1);
        run("p42", 0, 10, 4, 2, 1'b0, 1'b0, 1'b1);
        chk_out("stw", 1'b1, 1'b1);
        wr(2'd3, 32'hFFFF_FFFF);
        run("st", 1, 4, 4, 2, 1'b0, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) tick();
        if (sb_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
